taxi_sfp_ctrl: RTL and testbench

Per-cage SFP+ module management controller: the control side of the SFP cage, complementing the top level's reading of module status pins. It synchronizes and debounces the asynchronous present, fault and LOS pins. It sequences TX_DISABLE through insertion, enable, fault-retry and lockout, and drives the per-cage status LED. One instance per cage, in the core clock domain next to the MAC/PHY.

---
 rtl/taxi_sfp_ctrl_pkg.sv | 26 ++
 rtl/taxi_debounce.sv | 55 +++++
 rtl/taxi_sfp_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_taxi_sfp_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_sfp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : taxi_sfp_ctrl_pkg
//  Purpose  : Shared types and helpers for the SFP+ cage management controller.
//             Holds the controller state encoding and a width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package taxi_sfp_ctrl_pkg;

    // Encodings are visible on the 'state' port, so they are fixed values.
    typedef enum logic [2:0] {
        ST_ABSENT      = 3'd0,
        ST_INSERT_WAIT = 3'd1,
        ST_ENABLED     = 3'd2,
        ST_FAULT_HOLD  = 3'd3,
        ST_FAULT_LOCK  = 3'd4,
        ST_DISABLED    = 3'd5
    } sfp_ctrl_state_t;

    // Bits needed to index 'value' distinct codes, never less than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage : taxi_sfp_ctrl_pkg
`default_nettype wire

// File: rtl/taxi_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : taxi_debounce
//  Purpose  : Two-flop synchronizer followed by a consecutive-sample debouncer
//             for one asynchronous module pin.
//  Ports    : clk     - core clock
//             rst     - synchronous active-high reset
//             din_i   - raw asynchronous pin
//             dout_o  - debounced, clk-domain level (RST_VAL out of reset)
//  Revision : 1.0 - initial release
// ============================================================================
module taxi_debounce #(
    parameter int   CYC     = 1000,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic dout_o
);

    localparam int                 c_CNT_W    = $clog2(CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_out;
    logic [c_CNT_W-1:0] r_cnt;   // consecutive samples disagreeing with r_out

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
            r_out   <= RST_VAL;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din_i;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_out) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                // This sample is the CYC-th disagreeing one in a row.
                r_out <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign dout_o = r_out;

endmodule : taxi_debounce
`default_nettype wire

// File: rtl/taxi_sfp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : taxi_sfp_ctrl
//  Purpose  : Per-cage SFP+ management controller. Debounces the present,
//             fault and LOS pins, sequences TX_DISABLE through insertion,
//             enable, fault retry and lockout, and drives the cage LED.
//  Ports    : clk, rst        - core clock, synchronous active-high reset
//             sfp_npres       - module not-present pin (async)
//             sfp_tx_fault    - module TX fault pin (async)
//             sfp_los         - module loss-of-signal pin (async)
//             tx_enable_req   - management request to enable TX
//             link_up         - PHY block lock / link status
//             sfp_tx_disable  - TX_DISABLE pin drive (1 = disabled)
//             sfp_led         - cage status LED
//             present, los    - debounced module present / LOS
//             state           - controller state encoding
//             retry_cnt       - faults counted since last clear
//  Revision : 1.0 - initial release
// ============================================================================
module taxi_sfp_ctrl
    import taxi_sfp_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = 1000,
    parameter int INSERT_DELAY_CYC = 125000,
    parameter int FAULT_HOLD_CYC   = 12500,
    parameter int MAX_RETRIES      = 3,
    parameter int BLINK_CYC        = 12500000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   sfp_npres,
    input  logic                                   sfp_tx_fault,
    input  logic                                   sfp_los,
    input  logic                                   tx_enable_req,
    input  logic                                   link_up,
    output logic                                   sfp_tx_disable,
    output logic                                   sfp_led,
    output logic                                   present,
    output logic                                   los,
    output logic [2:0]                             state,
    output logic [clog2_min1(MAX_RETRIES+1)-1:0]   retry_cnt
);

    localparam int c_TMR_MAX = (INSERT_DELAY_CYC > FAULT_HOLD_CYC) ?
                               INSERT_DELAY_CYC : FAULT_HOLD_CYC;
    localparam int c_TMR_W   = clog2_min1(c_TMR_MAX + 1);
    localparam int c_RC_W    = clog2_min1(MAX_RETRIES + 1);
    localparam int c_BLINK_W = clog2_min1(BLINK_CYC);

    localparam logic [c_TMR_W-1:0]   c_TMR_INSERT = c_TMR_W'(INSERT_DELAY_CYC);
    localparam logic [c_TMR_W-1:0]   c_TMR_HOLD   = c_TMR_W'(FAULT_HOLD_CYC);
    localparam logic [c_TMR_W-1:0]   c_TMR_ONE    = c_TMR_W'(1);
    localparam logic [c_RC_W-1:0]    c_RC_MAX     = c_RC_W'(MAX_RETRIES);
    localparam logic [c_RC_W-1:0]    c_RC_ONE     = c_RC_W'(1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_CYC - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_ONE  = c_BLINK_W'(1);

    // ------------------------------------------------------------------
    // Pin conditioning
    // ------------------------------------------------------------------
    logic w_npres_db;
    logic w_fault_db;
    logic w_los_db;
    logic w_present;

    taxi_debounce #(.CYC(DEBOUNCE_CYC), .RST_VAL(1'b1)) u_db_npres (
        .clk    (clk),
        .rst    (rst),
        .din_i  (sfp_npres),
        .dout_o (w_npres_db)
    );

    taxi_debounce #(.CYC(DEBOUNCE_CYC), .RST_VAL(1'b0)) u_db_fault (
        .clk    (clk),
        .rst    (rst),
        .din_i  (sfp_tx_fault),
        .dout_o (w_fault_db)
    );

    taxi_debounce #(.CYC(DEBOUNCE_CYC), .RST_VAL(1'b1)) u_db_los (
        .clk    (clk),
        .rst    (rst),
        .din_i  (sfp_los),
        .dout_o (w_los_db)
    );

    assign w_present = ~w_npres_db;

    // ------------------------------------------------------------------
    // Control state machine
    // ------------------------------------------------------------------
    sfp_ctrl_state_t      r_state;
    sfp_ctrl_state_t      w_state_next;
    logic [c_TMR_W-1:0]   r_timer;
    logic [c_TMR_W-1:0]   w_timer_next;
    logic [c_RC_W-1:0]    r_retry;
    logic [c_RC_W-1:0]    w_retry_next;
    logic                 r_tx_disable;
    logic                 r_led;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_phase;

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_retry_next = r_retry;

        if (!w_present) begin
            // Removal overrides everything else, including a pending fault.
            w_state_next = ST_ABSENT;
            w_timer_next = '0;
            w_retry_next = '0;
        end else begin
            case (r_state)
                ST_ABSENT: begin
                    w_state_next = ST_INSERT_WAIT;
                    w_timer_next = c_TMR_INSERT;
                end
                ST_INSERT_WAIT: begin
                    if (!tx_enable_req) begin
                        w_state_next = ST_DISABLED;
                        w_timer_next = '0;
                    end else if (r_timer <= c_TMR_ONE) begin
                        w_state_next = ST_ENABLED;
                        w_timer_next = '0;
                    end else begin
                        w_timer_next = r_timer - c_TMR_ONE;
                    end
                end
                ST_ENABLED: begin
                    // A fault wins over a simultaneous request drop.
                    if (w_fault_db) begin
                        if (r_retry == c_RC_MAX) begin
                            w_state_next = ST_FAULT_LOCK;
                        end else begin
                            w_state_next = ST_FAULT_HOLD;
                            w_timer_next = c_TMR_HOLD;
                            w_retry_next = r_retry + c_RC_ONE;
                        end
                    end else if (!tx_enable_req) begin
                        w_state_next = ST_DISABLED;
                    end
                end
                ST_FAULT_HOLD: begin
                    if (!tx_enable_req) begin
                        w_state_next = ST_DISABLED;
                        w_timer_next = '0;
                    end else if (r_timer <= c_TMR_ONE) begin
                        w_state_next = ST_ENABLED;
                        w_timer_next = '0;
                    end else begin
                        w_timer_next = r_timer - c_TMR_ONE;
                    end
                end
                ST_FAULT_LOCK: begin
                    if (!tx_enable_req) begin
                        w_state_next = ST_DISABLED;
                    end
                end
                ST_DISABLED: begin
                    if (tx_enable_req) begin
                        w_state_next = ST_INSERT_WAIT;
                        w_timer_next = c_TMR_INSERT;
                    end
                end
                default: begin
                    w_state_next = ST_ABSENT;
                    w_timer_next = '0;
                    w_retry_next = '0;
                end
            endcase

            // An administrative disable forgives all previous faults.
            if (w_state_next == ST_DISABLED) begin
                w_retry_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ABSENT;
            r_timer      <= '0;
            r_retry      <= '0;
            r_tx_disable <= 1'b1;
            r_led        <= 1'b0;
            r_blink_cnt  <= '0;
            r_phase      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_retry      <= w_retry_next;
            // Derived from the next state so the pin never lags 'state'.
            r_tx_disable <= (w_state_next != ST_ENABLED);

            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_BLINK_ONE;
            end

            case (r_state)
                ST_ABSENT, ST_DISABLED:                     r_led <= 1'b0;
                ST_INSERT_WAIT, ST_FAULT_HOLD, ST_FAULT_LOCK: r_led <= r_phase;
                ST_ENABLED:                                 r_led <= link_up & ~w_los_db;
                default:                                    r_led <= 1'b0;
            endcase
        end
    end

    assign sfp_tx_disable = r_tx_disable;
    assign sfp_led        = r_led;
    assign present        = w_present;
    assign los            = w_los_db;
    assign state          = r_state;
    assign retry_cnt      = r_retry;

endmodule : taxi_sfp_ctrl
`default_nettype wire

// File: tb/tb_taxi_sfp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_taxi_sfp_ctrl
//  Purpose  : Self-checking bench for taxi_sfp_ctrl. A cycle-stamped reference
//             model pushes every change of the observable outputs into a
//             queue; a monitor pops and compares whenever the DUT outputs
//             change. Directed scenarios are followed by random pin activity.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_taxi_sfp_ctrl;

    localparam int DB = 4;
    localparam int ID = 16;
    localparam int FH = 8;
    localparam int MR = 2;
    localparam int BL = 4;

    logic       clk           = 1'b0;
    logic       rst           = 1'b1;
    logic       sfp_npres     = 1'b1;
    logic       sfp_tx_fault  = 1'b0;
    logic       sfp_los       = 1'b1;
    logic       tx_enable_req = 1'b0;
    logic       link_up       = 1'b0;
    logic       sfp_tx_disable;
    logic       sfp_led;
    logic       present;
    logic       los;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    always #5 clk = ~clk;

    taxi_sfp_ctrl #(
        .DEBOUNCE_CYC     (DB),
        .INSERT_DELAY_CYC (ID),
        .FAULT_HOLD_CYC   (FH),
        .MAX_RETRIES      (MR),
        .BLINK_CYC        (BL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sfp_npres      (sfp_npres),
        .sfp_tx_fault   (sfp_tx_fault),
        .sfp_los        (sfp_los),
        .tx_enable_req  (tx_enable_req),
        .link_up        (link_up),
        .sfp_tx_disable (sfp_tx_disable),
        .sfp_led        (sfp_led),
        .present        (present),
        .los            (los),
        .state          (state),
        .retry_cnt      (retry_cnt)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  st;
        logic        txd;
        logic        led;
        logic        pres;
        logic        los;
        logic [1:0]  rc;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // ------------------------------------------------------------------
    // Reference model, evaluated once per rising edge.
    // Pin index: 0 = npres, 1 = fault, 2 = los.
    // ------------------------------------------------------------------
    localparam logic [2:0] PIN_RST = 3'b101;
    logic [2:0] m_pipe1, m_pipe2, m_db, m_seen;
    int         m_last_agree [3];   // edge at which the pin last agreed
    int         m_st = 0;
    int         m_retry = 0;
    int         m_deadline = 0;
    int         m_edges = 0;        // edges since reset, drives blink phase
    logic       m_txd, m_led, m_phase;
    obs_t       m_obs, m_prev;
    bit         m_have = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_pipe1 = PIN_RST;
            m_pipe2 = PIN_RST;
            m_db    = PIN_RST;
            for (int i = 0; i < 3; i++) m_last_agree[i] = cyc;
            m_st = 0; m_retry = 0; m_deadline = 0; m_edges = 0;
            m_txd = 1'b1; m_led = 1'b0;
        end else begin
            // LED follows the state and pins as they stood before this edge.
            m_phase = ((m_edges / BL) % 2) == 1;
            case (m_st)
                1, 3, 4: m_led = m_phase;
                2:       m_led = link_up && !m_db[2];
                default: m_led = 1'b0;
            endcase

            if (m_db[0]) begin
                m_st = 0; m_retry = 0;
            end else begin
                case (m_st)
                    0: begin m_st = 1; m_deadline = cyc + ID; end
                    1: if (!tx_enable_req) m_st = 5;
                       else if (cyc == m_deadline) m_st = 2;
                    2: if (m_db[1]) begin
                           if (m_retry == MR) m_st = 4;
                           else begin m_retry++; m_st = 3; m_deadline = cyc + FH; end
                       end else if (!tx_enable_req) m_st = 5;
                    3: if (!tx_enable_req) m_st = 5;
                       else if (cyc == m_deadline) m_st = 2;
                    4: if (!tx_enable_req) m_st = 5;
                    default: if (tx_enable_req) begin m_st = 1; m_deadline = cyc + ID; end
                endcase
                if (m_st == 5) m_retry = 0;
            end
            m_txd   = (m_st != 2);
            m_edges = m_edges + 1;

            // A pin flips once it has disagreed for DB consecutive edges.
            m_seen  = m_pipe2;
            m_pipe2 = m_pipe1;
            m_pipe1 = {sfp_los, sfp_tx_fault, sfp_npres};
            for (int i = 0; i < 3; i++) begin
                if (m_seen[i] == m_db[i]) begin
                    m_last_agree[i] = cyc;
                end else if (cyc - m_last_agree[i] >= DB) begin
                    m_db[i] = m_seen[i];
                    m_last_agree[i] = cyc;
                end
            end
        end

        m_obs.cyc  = cyc;
        m_obs.st   = 3'(m_st);
        m_obs.txd  = m_txd;
        m_obs.led  = m_led;
        m_obs.pres = !m_db[0];
        m_obs.los  = m_db[2];
        m_obs.rc   = 2'(m_retry);
        if (!m_have || m_obs[8:0] != m_prev[8:0]) begin
            exp_q.push_back(m_obs);
            m_prev = m_obs;
            m_have = 1;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compare on every change of the DUT outputs.
    // ------------------------------------------------------------------
    obs_t d_obs, d_prev, d_exp;
    bit   d_have = 0;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            d_obs.cyc  = cyc;
            d_obs.st   = state;
            d_obs.txd  = sfp_tx_disable;
            d_obs.led  = sfp_led;
            d_obs.pres = present;
            d_obs.los  = los;
            d_obs.rc   = retry_cnt;
            if (!d_have || d_obs[8:0] !== d_prev[8:0]) begin
                d_have = 1;
                d_prev = d_obs;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard_unexpected: cyc=%0d st=%0d txd=%b led=%b pres=%b los=%b rc=%0d, no change was expected",
                             cyc, d_obs.st, d_obs.txd, d_obs.led, d_obs.pres, d_obs.los, d_obs.rc);
                end else begin
                    d_exp = exp_q.pop_front();
                    if (d_exp !== d_obs) begin
                        n_bad++;
                        $display("FAIL scoreboard: got cyc=%0d st=%0d txd=%b led=%b pres=%b los=%b rc=%0d, expected cyc=%0d st=%0d txd=%b led=%b pres=%b los=%b rc=%0d",
                                 d_obs.cyc, d_obs.st, d_obs.txd, d_obs.led, d_obs.pres, d_obs.los, d_obs.rc,
                                 d_exp.cyc, d_exp.st, d_exp.txd, d_exp.led, d_exp.pres, d_exp.los, d_exp.rc);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with a few absolute spot checks from the scenario timing.
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    int len;
    int act;

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);
        check("reset_state", 32'(state), 0);
        check("reset_txd", 32'(sfp_tx_disable), 1);
        check("reset_present", 32'(present), 0);
        check("reset_los", 32'(los), 1);
        check("reset_led", 32'(sfp_led), 0);

        // Short insertion glitch must be filtered out.
        sfp_npres = 1'b0; tick(3); sfp_npres = 1'b1; tick(10);
        check("glitch_present", 32'(present), 0);
        check("glitch_state", 32'(state), 0);
        check("glitch_txd", 32'(sfp_tx_disable), 1);

        // Insertion with TX requested, link healthy.
        tx_enable_req = 1'b1; sfp_los = 1'b0; link_up = 1'b1;
        sfp_npres = 1'b0; tick(30);
        check("insert_state", 32'(state), 2);
        check("insert_txd", 32'(sfp_tx_disable), 0);
        check("enabled_led", 32'(sfp_led), 1);

        // Single fault: hold then automatic retry.
        sfp_tx_fault = 1'b1; tick(6); sfp_tx_fault = 1'b0; tick(4);
        check("fault1_state", 32'(state), 3);
        check("fault1_retry", 32'(retry_cnt), 1);
        check("fault1_txd", 32'(sfp_tx_disable), 1);
        tick(12);
        check("retry_state", 32'(state), 2);
        check("retry_txd", 32'(sfp_tx_disable), 0);

        // Two more faults: second is retried, third locks out.
        sfp_tx_fault = 1'b1; tick(6); sfp_tx_fault = 1'b0; tick(20);
        check("fault2_retry", 32'(retry_cnt), 2);
        sfp_tx_fault = 1'b1; tick(6); sfp_tx_fault = 1'b0; tick(20);
        check("lock_state", 32'(state), 4);
        check("lock_retry", 32'(retry_cnt), 2);
        check("lock_txd", 32'(sfp_tx_disable), 1);
        tx_enable_req = 1'b0; tick(2);
        check("disable_state", 32'(state), 5);
        check("disable_retry", 32'(retry_cnt), 0);
        tx_enable_req = 1'b1; tick(5);
        check("reenable_wait", 32'(state), 1);
        tick(20);
        check("reenable_state", 32'(state), 2);

        // LOS suppresses the link LED.
        sfp_los = 1'b1; tick(10);
        check("los_led", 32'(sfp_led), 0);
        sfp_los = 1'b0; tick(10);

        // Removal during fault hold.
        sfp_tx_fault = 1'b1; tick(8);
        check("hold_state", 32'(state), 3);
        sfp_npres = 1'b1; tick(10);
        sfp_tx_fault = 1'b0;
        check("remove_state", 32'(state), 0);
        check("remove_retry", 32'(retry_cnt), 0);
        check("remove_txd", 32'(sfp_tx_disable), 1);
        check("remove_led", 32'(sfp_led), 0);

        // Reset in the middle of insertion.
        sfp_npres = 1'b0; tick(20);
        rst = 1'b1; tick(1);
        check("midrst_txd", 32'(sfp_tx_disable), 1);
        check("midrst_state", 32'(state), 0);
        rst = 1'b0; tick(2);

        // Random pin and control activity.
        for (int i = 0; i < 150; i++) begin
            act = $urandom_range(0, 9);
            case (act)
                0:       sfp_npres = (sfp_npres == 1'b1) ? 1'b0 : ($urandom_range(0, 2) == 0);
                1, 2, 3: begin
                    len = $urandom_range(1, 10);
                    sfp_tx_fault = 1'b1; tick(len); sfp_tx_fault = 1'b0;
                end
                4:       sfp_los = ~sfp_los;
                5:       tx_enable_req = (tx_enable_req == 1'b0) ? 1'b1 : ($urandom_range(0, 1) == 0);
                6:       link_up = ~link_up;
                7:       if ($urandom_range(0, 2) == 0) begin
                             rst = 1'b1; tick($urandom_range(1, 2)); rst = 1'b0;
                         end
                default: sfp_npres = (sfp_npres == 1'b1) ? 1'b0 : sfp_npres;
            endcase
            tick($urandom_range(1, 30));
        end

        tick(5);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_taxi_sfp_ctrl
`default_nettype wire
